key_speed_ctrl: RTL and testbench

KEY_SPEED_CTRL -- requirements
Module: key_speed_ctrl

---
 rtl/key_speed_ctrl_if.sv | 17 +
 rtl/key_speed_ctrl.sv | 141 ++++++++++++++
 tb/tb_key_speed_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_speed_ctrl_if.sv
// key_speed_ctrl_if -- bundle of the push-button inputs and the speed-select
// outputs of key_speed_ctrl.
//   key_up, key_dn : active-low push-buttons (0 = pressed)
//   s_out          : 3-bit registered speed select code
//   s_valid        : one-cycle pulse when s_out takes a new value
//   key_led        : one-hot echo of s_out
// master drives the keys and observes the outputs; slave is the controller side.
interface key_speed_ctrl_if;
  logic       key_up;
  logic       key_dn;
  logic [2:0] s_out;
  logic       s_valid;
  logic [7:0] key_led;

  modport master (output key_up, key_dn, input s_out, s_valid, key_led);
  modport slave  (input key_up, key_dn, output s_out, s_valid, key_led);
endinterface

// File: rtl/key_speed_ctrl.sv
// key_speed_ctrl -- two push-button speed selector.
// Each key is synchronized, debounced and edge-detected into a one-shot press
// event; a small FSM steps a saturating 3-bit speed code up or down once per
// press and waits for both keys to be released before accepting another.
// Ports:
//   Clk     : system clock, rising edge
//   RST_N   : asynchronous active-low reset
//   KEY_UP  : "faster" button, async, active-low
//   KEY_DN  : "slower" button, async, active-low
//   S_OUT   : registered speed select code (0..7)
//   S_VALID : one-cycle pulse in the first cycle S_OUT holds a new value
//   KEY_LED : registered one-hot of S_OUT
module key_speed_ctrl #(
  parameter int         DEB_W   = 20,
  parameter int         DEB_MAX = 999_999,
  parameter logic [2:0] S_INIT  = 3'd0
) (
  input  logic       Clk,
  input  logic       RST_N,
  input  logic       KEY_UP,
  input  logic       KEY_DN,
  output logic [2:0] S_OUT,
  output logic       S_VALID,
  output logic [7:0] KEY_LED
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INC  = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEB_MAX);

  function automatic logic [7:0] onehot(input logic [2:0] v);
    return 8'(1) << v;
  endfunction

  // bit 0 = UP key, bit 1 = DN key
  logic [1:0]       key_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [1:0]       evt;
  logic [DEB_W-1:0] cnt [2];

  logic [1:0] state;
  logic [1:0] state_next;
  logic [2:0] s_next;

  assign key_raw = {KEY_DN, KEY_UP};

  // Two-flop synchronizer; idles at 1 (released).
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: the stable state follows the synced input only after it has
  // differed for DEB_MAX+1 consecutive cycles; any agreement clears the count.
  // The press event is taken from a delayed copy of the stable state so that
  // it appears in the cycle after the 1->0 change of the stable flop.
  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      stable   <= '1;
      stable_d <= '1;
      evt      <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable_d <= stable;
      evt      <= stable_d & ~stable;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_TC) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Control FSM and next speed code.
  always_comb begin
    state_next = state;
    s_next     = S_OUT;
    case (state)
      IDLE: begin
        if (evt[0] && evt[1]) begin
          state_next = HOLD;
        end else if (evt[0]) begin
          state_next = INC;
        end else if (evt[1]) begin
          state_next = DEC;
        end
      end
      INC: begin
        if (S_OUT != 3'd7) begin
          s_next = S_OUT + 3'd1;
        end
        state_next = HOLD;
      end
      DEC: begin
        if (S_OUT != 3'd0) begin
          s_next = S_OUT - 3'd1;
        end
        state_next = HOLD;
      end
      HOLD: begin
        if (&stable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      S_OUT   <= S_INIT;
      S_VALID <= 1'b0;
      KEY_LED <= onehot(S_INIT);
    end else begin
      state   <= state_next;
      S_OUT   <= s_next;
      S_VALID <= (s_next != S_OUT);
      KEY_LED <= onehot(s_next);
    end
  end

endmodule

// File: tb/tb_key_speed_ctrl.sv
// tb_key_speed_ctrl -- self-checking bench for key_speed_ctrl (DEB_MAX = 3).
// A reference model derives the expected outputs every cycle from the
// recorded key history: two-cycle synchronizer delay, run-length debounce,
// press-to-decision delay, saturating step and release-gated re-arm.
module tb_key_speed_ctrl;

  localparam int DEB_W   = 4;
  localparam int DEB_MAX = 3;
  localparam int MAXC    = 8192;

  logic Clk = 1'b0;
  logic RST_N;

  key_speed_ctrl_if bus ();

  key_speed_ctrl #(
    .DEB_W   (DEB_W),
    .DEB_MAX (DEB_MAX),
    .S_INIT  (3'd0)
  ) dut (
    .Clk     (Clk),
    .RST_N   (RST_N),
    .KEY_UP  (bus.key_up),
    .KEY_DN  (bus.key_dn),
    .S_OUT   (bus.s_out),
    .S_VALID (bus.s_valid),
    .KEY_LED (bus.key_led)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int g     = 0;   // index of the next rising edge
  int rbase = 0;   // first edge after the last reset release
  int vcount = 0;  // S_VALID pulses seen

  // model history, indexed by edge number
  bit rawu [MAXC];
  bit rawd [MAXC];
  bit stu  [MAXC];
  bit std  [MAXC];
  bit fau  [MAXC];
  bit fad  [MAXC];

  // model outputs / arming
  logic [2:0] exp_s;
  logic       exp_valid;
  bit         ready;
  int         pend_at;
  bit         pend_up;
  int         hold_from;

  function automatic bit syn(input int n, input bit dn);
    if (n - 2 < rbase) return 1'b1;
    return dn ? rawd[n-2] : rawu[n-2];
  endfunction

  function automatic bit stab(input int n, input bit dn);
    if (n < rbase) return 1'b1;
    return dn ? std[n] : stu[n];
  endfunction

  task automatic model_step(input int n);
    bit sp0, sp1, f0, f1, ue, de;
    logic [2:0] nx;
    rawu[n] = bus.key_up;
    rawd[n] = bus.key_dn;
    sp0 = stab(n - 1, 1'b0);
    sp1 = stab(n - 1, 1'b1);
    f0 = 1'b1;
    f1 = 1'b1;
    for (int k = 0; k <= DEB_MAX; k++) begin
      if (syn(n - k, 1'b0) == sp0) f0 = 1'b0;
      if (syn(n - k, 1'b1) == sp1) f1 = 1'b0;
    end
    stu[n] = f0 ? ~sp0 : sp0;
    std[n] = f1 ? ~sp1 : sp1;
    fau[n] = sp0 & ~stu[n];
    fad[n] = sp1 & ~std[n];

    exp_valid = 1'b0;
    if (pend_at == n) begin
      if (pend_up) nx = (exp_s == 3'd7) ? 3'd7 : exp_s + 3'd1;
      else         nx = (exp_s == 3'd0) ? 3'd0 : exp_s - 3'd1;
      exp_valid = (nx != exp_s);
      exp_s = nx;
    end

    ue = (n - 2 >= rbase) && fau[n-2];
    de = (n - 2 >= rbase) && fad[n-2];
    if (ready) begin
      if (ue || de) begin
        ready = 1'b0;
        if (ue && de) begin
          hold_from = n + 1;
        end else begin
          pend_at   = n + 1;
          pend_up   = ue;
          hold_from = n + 2;
        end
      end
    end else if (n >= hold_from && sp0 && sp1) begin
      ready = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, g);
    end
  endtask

  task automatic check_outputs();
    chk("s_out",   32'(bus.s_out),   32'(exp_s));
    chk("s_valid", 32'(bus.s_valid), 32'(exp_valid));
    chk("key_led", 32'(bus.key_led), 32'(8'(1) << exp_s));
  endtask

  task automatic tick();
    @(posedge Clk);
    if (g >= MAXC - 1) begin
      fails++;
      $display("FAIL cycle_budget: got edge %0d expected below %0d", g, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (RST_N) model_step(g);
    else rbase = g + 1;
    g++;
    #1;
    if (bus.s_valid === 1'b1) vcount++;
    check_outputs();
  endtask

  task automatic do_reset(input int edges);
    RST_N = 1'b0;
    #1;
    exp_s     = 3'd0;
    exp_valid = 1'b0;
    ready     = 1'b1;
    pend_at   = -1;
    hold_from = 0;
    check_outputs();
    repeat (edges) tick();
    @(negedge Clk);
    RST_N = 1'b1;
  endtask

  task automatic press(input bit up, input bit dn, input int len, input int gap);
    bus.key_up = ~up;
    bus.key_dn = ~dn;
    repeat (len) tick();
    bus.key_up = 1'b1;
    bus.key_dn = 1'b1;
    repeat (gap) tick();
  endtask

  initial begin
    int d;
    int t_hit;
    int v0;
    int us, ul, ds, dl, tot, mode;
    bit use_up, use_dn;

    RST_N = 1'b1;
    bus.key_up = 1'b1;
    bus.key_dn = 1'b1;
    #2;
    do_reset(2);

    // Single UP press: 0 -> 1 seven cycles after the synced low.
    vcount = 0;
    t_hit = -1;
    bus.key_up = 1'b0;
    d = g;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.s_out === 3'd1 && t_hit < 0) t_hit = g - 1;
    end
    bus.key_up = 1'b1;
    repeat (20) tick();
    chk("up_latency", 32'(t_hit), 32'(d + 8));
    chk("up_pulses",  32'(vcount), 32'd1);
    chk("up_led",     32'(bus.key_led), 32'h02);

    // Short glitch rejected.
    vcount = 0;
    press(1'b1, 1'b0, 3, 20);
    chk("glitch_s", 32'(bus.s_out), 32'd1);
    chk("glitch_pulses", 32'(vcount), 32'd0);

    // Eight presses from reset saturate at 7.
    do_reset(1);
    vcount = 0;
    repeat (7) press(1'b1, 1'b0, 10, 15);
    chk("sat7_pulses", 32'(vcount), 32'd7);
    v0 = vcount;
    press(1'b1, 1'b0, 10, 15);
    chk("sat7_extra_pulse", 32'(vcount - v0), 32'd0);
    chk("sat7_s",   32'(bus.s_out), 32'd7);
    chk("sat7_led", 32'(bus.key_led), 32'h80);

    // Down to 5, then a long DN hold steps only once.
    repeat (2) press(1'b0, 1'b1, 10, 15);
    chk("dn_to5", 32'(bus.s_out), 32'd5);
    vcount = 0;
    press(1'b0, 1'b1, 100, 20);
    chk("hold_dn_s", 32'(bus.s_out), 32'd4);
    chk("hold_dn_pulses", 32'(vcount), 32'd1);

    // Both keys together: no change, and presses during HOLD are ignored.
    vcount = 0;
    bus.key_up = 1'b0;
    bus.key_dn = 1'b0;
    repeat (20) tick();
    bus.key_up = 1'b1;
    repeat (10) tick();
    bus.key_up = 1'b0;
    repeat (20) tick();
    bus.key_up = 1'b1;
    bus.key_dn = 1'b1;
    repeat (20) tick();
    chk("both_s", 32'(bus.s_out), 32'd4);
    chk("both_pulses", 32'(vcount), 32'd0);
    press(1'b1, 1'b0, 10, 15);
    chk("after_both_s", 32'(bus.s_out), 32'd5);

    // Randomized press patterns checked cycle by cycle by the model.
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 3));
      ul = int'($urandom_range(1, 12));
      dl = int'($urandom_range(1, 12));
      us = 0;
      ds = (mode == 2) ? 0 : int'($urandom_range(0, 8));
      use_up = (mode != 1);
      use_dn = (mode != 0);
      tot = ((us + ul) > (ds + dl) ? (us + ul) : (ds + dl)) + int'($urandom_range(0, 14));
      for (int t = 0; t < tot; t++) begin
        bus.key_up = ~(use_up && t >= us && t < us + ul);
        bus.key_dn = ~(use_dn && t >= ds && t < ds + dl);
        tick();
      end
      bus.key_up = 1'b1;
      bus.key_dn = 1'b1;
    end
    repeat (20) tick();

    // Reset while DN is mid-debounce (counter = 2), key kept held.
    bus.key_dn = 1'b0;
    repeat (4) tick();
    vcount = 0;
    do_reset(2);
    repeat (20) tick();
    bus.key_dn = 1'b1;
    repeat (15) tick();
    chk("rst_dn_s", 32'(bus.s_out), 32'd0);
    chk("rst_dn_pulses", 32'(vcount), 32'd0);

    // Same with UP held: increment only after a full interval from release.
    bus.key_up = 1'b0;
    repeat (4) tick();
    do_reset(2);
    vcount = 0;
    t_hit = -1;
    d = g;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.s_out === 3'd1 && t_hit < 0) t_hit = g - 1;
    end
    bus.key_up = 1'b1;
    repeat (15) tick();
    chk("rst_up_latency", 32'(t_hit), 32'(d + 8));
    chk("rst_up_pulses", 32'(vcount), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
